// File: rtl/multi_clk_div.sv
// Multi-channel programmable clock divider with double-buffered period/high-time.
// Latency: clkout follows en by one edge; new settings take effect at a period wrap or sync.
// No backpressure: outputs are free-running registered levels and one-cycle pulses.
module multi_clk_div #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] period,
  input  logic [CHANNELS*WIDTH-1:0] high,
  input  logic                      sync,
  output logic [CHANNELS-1:0]       clkout,
  output logic [CHANNELS-1:0]       tick
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [WIDTH-1:0] in_p, in_h;
    logic [WIDTH-1:0] pend_p_q, pend_p_d, pend_h_q, pend_h_d;
    logic [WIDTH-1:0] act_p_q, act_p_d, act_h_q, act_h_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;
    logic             clkout_q, clkout_d;
    logic             tick_q, tick_d;
    logic             wrap;

    assign in_p = period[g*WIDTH +: WIDTH];
    assign in_h = high[g*WIDTH +: WIDTH];

    // run_q guarantees act_p_q >= 2, so act_p_q - 1 cannot underflow here.
    assign wrap = run_q && (cnt_q == act_p_q - ONE);

    // Next-state: pending capture, boundary transfer, counter and output decode.
    always_comb begin
      pend_p_d = pend_p_q;
      pend_h_d = pend_h_q;
      act_p_d  = act_p_q;
      act_h_d  = act_h_q;
      if (load[g]) begin
        pend_p_d = in_p;
        pend_h_d = in_h;
      end
      // An idle channel takes a load immediately; a running one waits for a boundary.
      if (load[g] && !run_q) begin
        act_p_d = in_p;
        act_h_d = in_h;
      end else if (sync || wrap) begin
        act_p_d = pend_p_q;
        act_h_d = pend_h_q;
      end
      run_d    = en[g] && (act_p_d >= TWO);
      // Count only while continuing an existing period; any start, restart or wrap goes to 0.
      cnt_d    = (run_d && run_q && !sync && !wrap) ? cnt_q + ONE : '0;
      clkout_d = run_d && (cnt_d < act_h_d);
      tick_d   = wrap && !sync;
    end

    // Per-channel state registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        pend_p_q <= '0;
        pend_h_q <= '0;
        act_p_q  <= '0;
        act_h_q  <= '0;
        cnt_q    <= '0;
        run_q    <= 1'b0;
        clkout_q <= 1'b0;
        tick_q   <= 1'b0;
      end else begin
        pend_p_q <= pend_p_d;
        pend_h_q <= pend_h_d;
        act_p_q  <= act_p_d;
        act_h_q  <= act_h_d;
        cnt_q    <= cnt_d;
        run_q    <= run_d;
        clkout_q <= clkout_d;
        tick_q   <= tick_d;
      end
    end

    assign clkout[g] = clkout_q;
    assign tick[g]   = tick_q;
  end

endmodule

// File: tb/tb_multi_clk_div.sv
// Scoreboard bench for multi_clk_div: stimulus pushes expected outputs, monitor pops and compares.
// Each queued entry describes the outputs after the next rising edge.
// Only the channels selected by the entry mask are compared.
module tb_multi_clk_div;

  localparam int CH = 4;
  localparam int W  = 16;

  logic            clk;
  logic            rst;
  logic [CH-1:0]   en, load;
  logic [CH*W-1:0] period, high;
  logic            sync;
  logic [CH-1:0]   clkout, tick;

  multi_clk_div #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .period(period), .high(high),
    .sync(sync), .clkout(clkout), .tick(tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [CH-1:0] m;
    logic [CH-1:0] c;
    logic [CH-1:0] t;
    string         nm;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Monitor: samples after each rising edge and compares against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_tests++;
        if (((clkout & e.m) !== (e.c & e.m)) || ((tick & e.m) !== (e.t & e.m))) begin
          n_fail++;
          $display("FAIL %s: clkout=%b tick=%b, expected clkout=%b tick=%b (mask %b)",
                   e.nm, clkout & e.m, tick & e.m, e.c & e.m, e.t & e.m, e.m);
        end
      end
    end
  end

  task automatic push_exp(input logic [CH-1:0] m, input logic [CH-1:0] c,
                          input logic [CH-1:0] t, input string nm);
    exp_t e;
    e.m = m; e.c = c; e.t = t; e.nm = nm;
    q.push_back(e);
  endtask

  // Advance to the next falling edge and drop the one-cycle strobes.
  task automatic step();
    @(negedge clk);
    load = '0;
    sync = 1'b0;
  endtask

  task automatic set_ch(input int ch, input logic [W-1:0] p, input logic [W-1:0] h);
    period[ch*W +: W] = p;
    high[ch*W +: W]   = h;
  endtask

  // Expect n edges on one channel; bit k of the patterns is the value after edge k.
  task automatic expect_seq(input int ch, input int n, input logic [63:0] cp,
                            input logic [63:0] tp, input string nm);
    logic [CH-1:0] m, c, t;
    for (int k = 0; k < n; k++) begin
      if (k > 0) step();
      m = '0; c = '0; t = '0;
      m[ch] = 1'b1;
      c[ch] = cp[k];
      t[ch] = tp[k];
      push_exp(m, c, t, $sformatf("%s[%0d]", nm, k));
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

  // Directed stimulus.
  initial begin
    logic [7:0] c0, t0, c1, t1;
    rst = 1'b1; en = '0; load = '0; sync = 1'b0; period = '0; high = '0;
    #2 rst = 1'b0;
    #1 chk("reset_out", {28'd0, clkout, tick} , 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Idle after reset: enabled but never loaded.
    en = '1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) step();
      push_exp('1, '0, '0, "idle_after_reset");
    end
    step();
    en = '0;

    // Basic divide P=4 H=2.
    step();
    set_ch(0, 4, 2); load = 4'b0001; en[0] = 1'b1;
    expect_seq(0, 14, 64'h3333, 64'h1110, "basic");

    // Glitch-free update at cnt=1: finish 1,1,0,0 then 1,0,0,0,0,0.
    step();
    set_ch(0, 6, 1); load = 4'b0001;
    expect_seq(0, 15, 64'h4104, 64'h4104, "update");
    step();
    en[0] = 1'b0;
    expect_seq(0, 1, 64'h0, 64'h0, "disable0");

    // Degenerate values on channel 2.
    step();
    set_ch(2, 1, 1); load = 4'b0100; en[2] = 1'b1;
    expect_seq(2, 6, 64'h0, 64'h0, "p1");
    step();
    set_ch(2, 5, 0); load = 4'b0100;
    expect_seq(2, 11, 64'h0, 64'h420, "h0");
    step();
    en[2] = 1'b0;
    expect_seq(2, 1, 64'h0, 64'h0, "disable2");
    step();
    set_ch(2, 5, 7); load = 4'b0100; en[2] = 1'b1;
    expect_seq(2, 11, 64'h7ff, 64'h420, "h_ge_p");
    step();
    en[2] = 1'b0;
    expect_seq(2, 1, 64'h0, 64'h0, "disable2b");

    // Sync alignment: ch1 starts first, ch0 three edges later; sync lands on ch0's wrap.
    step();
    set_ch(0, 4, 2); set_ch(1, 8, 4); load = 4'b0011; en[1] = 1'b1;
    expect_seq(1, 3, 64'h7, 64'h0, "ch1_start");
    step();
    en[0] = 1'b1;
    expect_seq(0, 4, 64'h3, 64'h0, "ch0_start");
    step();
    sync = 1'b1;
    push_exp(4'b0011, 4'b0011, 4'b0000, "sync_edge");
    c0 = 8'h99; t0 = 8'h88; c1 = 8'h87; t1 = 8'h80;
    for (int k = 0; k < 8; k++) begin
      step();
      push_exp(4'b0011, {2'b00, c1[k], c0[k]}, {2'b00, t1[k], t0[k]},
               $sformatf("after_sync[%0d]", k));
    end

    // Enable toggling on ch1.
    step();
    expect_seq(1, 1, 64'h1, 64'h0, "ch1_high");
    step();
    en[1] = 1'b0;
    expect_seq(1, 3, 64'h0, 64'h0, "ch1_off");
    step();
    en[1] = 1'b1;
    expect_seq(1, 9, 64'h10f, 64'h100, "ch1_reen");

    // Load on a wrap edge applies one period later.
    step();
    expect_seq(1, 7, 64'h07, 64'h0, "ch1_to_wrap");
    step();
    set_ch(1, 2, 1); load = 4'b0010;
    expect_seq(1, 14, 64'h150f, 64'h1501, "load_on_wrap");

    // Asynchronous reset while ch1 is high.
    step();
    expect_seq(1, 1, 64'h1, 64'h1, "pre_reset");
    @(posedge clk);
    #3 rst = 1'b0;
    #1 chk("async_reset", {28'd0, clkout, tick}, 32'd0);
    @(negedge clk);
    rst = 1'b1; en = '1; load = '0; sync = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) step();
      push_exp('1, '0, '0, "idle_after_rerelease");
    end

    repeat (2) @(posedge clk);
    #3 chk("queue_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
